// File: rtl/rambus_stream_reader.sv
// rambus_stream_reader
// Wishbone classic read-only initiator on the OpenRAM rambus (port B).
// Fetches a run of words from the 1 kB SRAM into a small prefetch FIFO and
// presents them on a valid/ready stream, optionally looping over the table.
//
// Ports
//   wb_clk_i, wb_rst_ni     clock, async active-low reset
//   start_i, abort_i        transfer control (start ignored while busy)
//   base_adr_i, length_i,   transfer parameters, latched on an accepted start
//   loop_i
//   busy_o, done_o          status (done_o pulses when the last word leaves)
//   rambus_wb_*             Wishbone master side of the rambus
//   data_o, valid_o,        output stream, transfer on valid_o && ready_i
//   ready_i
module rambus_stream_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  base_adr_i,
  input  logic [8:0]  length_i,
  input  logic        loop_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rambus_wb_clk_o,
  output logic        rambus_wb_rst_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [31:0] rambus_wb_dat_o,
  output logic [9:0]  rambus_wb_adr_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] REQ   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state_q, state_n;
  logic [7:0]    word_adr_q, word_adr_n;
  logic [8:0]    remaining_q, remaining_n;
  logic [7:0]    base_q, base_n;
  logic [8:0]    len_q, len_n;
  logic          loop_q, loop_n;
  logic          stb_q, busy_q, done_q, done_n;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0] count_q, count_n;
  logic [31:0]   data_q, data_n;
  logic          valid_q, valid_n;
  logic          push, pop, flush;
  logic [8:0]    len_clamped;

  // Fixed rambus attributes: read-only, full-word accesses
  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_dat_o = 32'h0;
  assign rambus_wb_stb_o = stb_q;
  assign rambus_wb_cyc_o = stb_q;
  assign rambus_wb_adr_o = {word_adr_q, 2'b00};
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign data_o          = data_q;
  assign valid_o         = valid_q;

  assign len_clamped = (length_i > 9'd256) ? 9'd256 : length_i;

  // Next-state: FIFO bookkeeping first, then the transfer FSM
  always_comb begin
    state_n     = state_q;
    word_adr_n  = word_adr_q;
    remaining_n = remaining_q;
    base_n      = base_q;
    len_n       = len_q;
    loop_n      = loop_q;
    done_n      = 1'b0;

    flush = abort_i && (state_q != IDLE);
    push  = (state_q == REQ) && rambus_wb_ack_i && !flush;
    pop   = valid_q && ready_i;

    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      data_n   = '0;
      valid_n  = 1'b0;
    end else begin
      wr_ptr_n = wr_ptr_q + AW'(push);
      rd_ptr_n = rd_ptr_q + AW'(pop);
      count_n  = count_q + CW'(push) - CW'(pop);
      valid_n  = (count_n != CW'(0));
      // Head register: bypass incoming data when it lands in an empty slot
      if (count_n == CW'(0))
        data_n = '0;
      else if ((count_q - CW'(pop)) == CW'(0))
        data_n = rambus_wb_dat_i;
      else
        data_n = mem[rd_ptr_n];
    end

    case (state_q)
      // FIFO is always empty here, so the first request issues immediately
      IDLE: begin
        if (start_i && (length_i != 9'd0)) begin
          state_n     = REQ;
          word_adr_n  = base_adr_i;
          remaining_n = len_clamped;
          base_n      = base_adr_i;
          len_n       = len_clamped;
          loop_n      = loop_i;
        end
      end
      FETCH: begin
        if (count_q < CW'(FIFO_DEPTH))
          state_n = REQ;
      end
      REQ: begin
        if (rambus_wb_ack_i) begin
          word_adr_n  = word_adr_q + 8'd1;
          remaining_n = remaining_q - 9'd1;
          state_n     = FETCH;
          if (remaining_q == 9'd1) begin
            if (loop_q) begin
              word_adr_n  = base_q;
              remaining_n = len_q;
            end else begin
              state_n = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (count_n == CW'(0)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (flush) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  // Control and status registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      word_adr_q  <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      word_adr_q  <= word_adr_n;
      remaining_q <= remaining_n;
      base_q      <= base_n;
      len_q       <= len_n;
      loop_q      <= loop_n;
      stb_q       <= (state_n == REQ);
      busy_q      <= (state_n != IDLE);
      done_q      <= done_n;
      wr_ptr_q    <= wr_ptr_n;
      rd_ptr_q    <= rd_ptr_n;
      count_q     <= count_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
    end
  end

  // FIFO storage; contents are don't-care until counted as valid
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr_q] <= rambus_wb_dat_i;
  end

endmodule

// File: tb/tb_rambus_stream_reader.sv
module tb_rambus_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, abort, loop, ready;
  logic [7:0]  base;
  logic [8:0]  len;
  logic        busy, done, r_clk, r_rst, stb, cyc, we, ack, valid;
  logic [3:0]  sel;
  logic [31:0] dato, dati, data;
  logic [9:0]  adr;

  logic [31:0] ram [256];
  logic [31:0] exp_q[$];
  logic [9:0]  exp_adr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_xfer = 0;
  int          n_acks = 0;
  int          lat_max = 0;
  bit          expect_done = 1'b0;
  bit          done_due = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          hold_ack = 1'b0;

  always #5 clk = ~clk;

  rambus_stream_reader #(.FIFO_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .start_i(start), .abort_i(abort), .base_adr_i(base), .length_i(len), .loop_i(loop),
    .busy_o(busy), .done_o(done),
    .rambus_wb_clk_o(r_clk), .rambus_wb_rst_o(r_rst),
    .rambus_wb_stb_o(stb), .rambus_wb_cyc_o(cyc), .rambus_wb_we_o(we),
    .rambus_wb_sel_o(sel), .rambus_wb_dat_o(dato), .rambus_wb_adr_o(adr),
    .rambus_wb_ack_i(ack), .rambus_wb_dat_i(dati),
    .data_o(data), .valid_o(valid), .ready_i(ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM responder: acks after a random wait, checks each request address
  initial begin : responder
    int wc;
    int lat;
    wc = 0;
    lat = 0;
    ack = 1'b0;
    dati = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0;
        wc = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if (stb === 1'b1 && !hold_ack) begin
        if (wc >= lat) begin
          ack = 1'b1;
          dati = ram[adr[9:2]];
          n_acks++;
          check("stb_eq_cyc", 32'(cyc), 32'(stb));
          if (exp_adr_q.size() == 0) fail("unexpected_req", 32'(adr));
          else check("req_adr", 32'(adr), 32'(exp_adr_q.pop_front()));
          wc = 0;
          lat = $urandom_range(0, lat_max);
        end else begin
          wc++;
        end
      end
    end
  end

  // Stream monitor / scoreboard
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (done_due) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        done_due = 1'b0;
      end else if (done === 1'b1) begin
        fail("spurious_done", 32'(done));
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail("extra_word", data);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", data, e);
          n_xfer++;
          if (exp_q.size() == 0 && expect_done) done_due = 1'b1;
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issue a start; when push_exp is set, queue the expected words/addresses
  task automatic do_start(input logic [7:0] b, input logic [8:0] l, input logic lp, input bit push_exp);
    int el;
    el = (l > 9'd256) ? 256 : int'(l);
    if (push_exp) begin
      for (int i = 0; i < el; i++) begin
        exp_q.push_back(ram[8'(int'(b) + i)]);
        exp_adr_q.push_back({8'(int'(b) + i), 2'b00});
      end
      expect_done = !lp;
    end
    base = b; len = l; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
    base = 8'($urandom); len = 9'($urandom); loop = 1'($urandom);
    if (push_exp && el != 0) begin
      check("start_busy", 32'(busy), 32'd1);
      check("start_stb", 32'(stb), 32'd1);
      check("start_adr", 32'(adr), 32'({b, 2'b00}));
    end
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while ((busy === 1'b1 || exp_q.size() != 0 || done_due) && c < budget) begin
      tick();
      c++;
    end
    check("xfer_complete", 32'(c < budget), 32'd1);
    check("adr_seq_consumed", 32'(exp_adr_q.size()), 32'd0);
  endtask

  task automatic wait_stb(input int budget);
    int c;
    c = 0;
    while (stb !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check("wait_stb", 32'(stb), 32'd1);
  endtask

  initial begin : stimulus
    int a0, x0, c;
    logic [7:0] b;
    start = 1'b0; abort = 1'b0; loop = 1'b0; ready = 1'b0;
    base = '0; len = '0;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_out", 32'(r_rst), 32'd1);
    check("const_we", 32'(we), 32'd0);
    check("const_sel", 32'(sel), 32'hF);
    check("const_dat", dato, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_out_release", 32'(r_rst), 32'd0);
    check("clk_forward", 32'(r_clk), 32'(clk));

    // Basic read
    for (int i = 0; i < 4; i++) ram[16 + i] = 32'hA0 + 32'(i);
    ready = 1'b1;
    do_start(8'h10, 9'd4, 1'b0, 1'b1);
    wait_done(200);

    // Zero length: no activity
    a0 = n_acks;
    do_start(8'h33, 9'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_stb", 32'(stb), 32'd0);
      tick();
    end
    check("len0_acks", 32'(n_acks - a0), 32'd0);

    // Backpressure: FIFO fills to 4, no 5th request
    ready = 1'b0;
    lat_max = 2;
    b = 8'($urandom);
    a0 = n_acks;
    do_start(b, 9'd8, 1'b0, 1'b1);
    repeat (40) tick();
    check("bp_acks", 32'(n_acks - a0), 32'd4);
    check("bp_stb", 32'(stb), 32'd0);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_head", data, ram[b]);
    ready = 1'b1;
    wait_done(300);

    // Address wrap-around
    lat_max = 1;
    do_start(8'hFE, 9'd4, 1'b0, 1'b1);
    wait_done(200);

    // Start while busy is ignored
    do_start(8'($urandom), 9'd6, 1'b0, 1'b1);
    tick();
    do_start(8'($urandom), 9'd5, 1'b1, 1'b0);
    wait_done(300);

    // Loop and abort
    ram[8'h20] = 32'hAAAA0020;
    ram[8'h21] = 32'hBBBB0021;
    expect_done = 1'b0;
    for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 1) ? ram[8'h21] : ram[8'h20]);
    for (int i = 0; i < 16; i++) exp_adr_q.push_back((i % 2 == 1) ? 10'h084 : 10'h080);
    x0 = n_xfer;
    lat_max = 0;
    ready = 1'b1;
    do_start(8'h20, 9'd2, 1'b1, 1'b0);
    c = 0;
    while (n_xfer - x0 < 7 && c < 300) begin
      tick();
      c++;
      ready = (n_xfer - x0 < 7);
    end
    hold_ack = 1'b1;
    check("loop_count", 32'(n_xfer - x0), 32'd7);
    wait_stb(30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_stb", 32'(stb), 32'd0);
    check("abort_cyc", 32'(cyc), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_adr_q.delete();
    hold_ack = 1'b0;
    ready = 1'b1;
    do_start(8'($urandom), 9'd3, 1'b0, 1'b1);
    wait_done(200);

    // Randomized transfers, including an over-length request
    rdy_rand = 1'b1;
    lat_max = 2;
    for (int t = 0; t < 6; t++) begin
      do_start(8'($urandom), (t == 5) ? 9'd300 : 9'($urandom_range(1, 24)), 1'b0, 1'b1);
      wait_done(4000);
    end
    rdy_rand = 1'b0;

    // Async reset while a request is pending
    tick();
    ready = 1'b0;
    lat_max = 0;
    do_start(8'($urandom), 9'd5, 1'b0, 1'b1);
    repeat (3) tick();
    hold_ack = 1'b1;
    wait_stb(30);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stb", 32'(stb), 32'd0);
    check("arst_cyc", 32'(cyc), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data", data, 32'd0);
    check("arst_adr", 32'(adr), 32'd0);
    exp_q.delete();
    exp_adr_q.delete();
    expect_done = 1'b0;
    done_due = 1'b0;
    hold_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ready = 1'b1;
    do_start(8'($urandom), 9'd3, 1'b0, 1'b1);
    wait_done(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
